// File: rtl/plru_replacer.sv
// rtl/plru_replacer.sv - tree pseudo-LRU victim selection for a set-associative cache
// Per-set PLRU trees, a reset sweep, one-cycle lookup and a one-deep access pipeline with forwarding.
module plru_replacer #(
  parameter int NUM_OF_WAYS = 4,
  parameter int NUM_OF_SETS = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           ready_o,
  input  logic                           lookup_valid_i,
  input  logic [$clog2(NUM_OF_SETS)-1:0] lookup_set_i,
  output logic                           victim_valid_o,
  output logic [$clog2(NUM_OF_WAYS)-1:0] victim_way_o,
  input  logic                           access_valid_i,
  input  logic [$clog2(NUM_OF_SETS)-1:0] access_set_i,
  input  logic [$clog2(NUM_OF_WAYS)-1:0] access_way_i
);

  localparam int WW = $clog2(NUM_OF_WAYS);
  localparam int SW = $clog2(NUM_OF_SETS);

  typedef logic [NUM_OF_WAYS-1:0] tree_t;
  typedef enum logic {INIT, READY} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   init_cnt_q;
  tree_t           tree_mem [NUM_OF_SETS];
  logic            s1_valid_q;
  logic [SW-1:0]   s1_set_q;
  logic [WW-1:0]   s1_way_q;
  tree_t           s1_new;
  tree_t           lookup_tree;
  logic            lookup_fire;
  logic            access_fire;

  // Node index grows one bit per layer: appending the node's bit selects the child.
  function automatic logic [WW-1:0] find_victim(input tree_t t);
    logic [WW:0] node;
    node = (WW+1)'(1);
    for (int k = 0; k < WW; k++) begin
      node = {node[WW-1:0], t[node[WW-1:0]]};
    end
    return node[WW-1:0];
  endfunction

  function automatic tree_t touch(input tree_t t, input logic [WW-1:0] way);
    tree_t         r;
    logic [WW:0]   node;
    logic [WW-1:0] wsh;
    r = t;
    for (int k = 0; k < WW; k++) begin
      node = {1'b1, way} >> (WW - k);
      wsh  = way << k;
      r[node[WW-1:0]] = ~wsh[WW-1];
    end
    return r;
  endfunction

  assign ready_o     = (state_q == READY);
  assign lookup_fire = lookup_valid_i && ready_o;
  assign access_fire = access_valid_i && ready_o;

  // The stage-1 result is both the write data and the forwarded tree for a same-set lookup.
  assign s1_new      = touch(tree_mem[s1_set_q], s1_way_q);
  assign lookup_tree = (s1_valid_q && (s1_set_q == lookup_set_i)) ? s1_new : tree_mem[lookup_set_i];

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_cnt_q == SW'(NUM_OF_SETS - 1)) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= INIT;
      init_cnt_q     <= '0;
      s1_valid_q     <= 1'b0;
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
    end else begin
      state_q        <= state_d;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + SW'(1);
      s1_valid_q     <= access_fire;
      victim_valid_o <= lookup_fire;
      if (lookup_fire) victim_way_o <= find_victim(lookup_tree);
    end
  end

  always_ff @(posedge clk) begin
    if (access_fire) begin
      s1_set_q <= access_set_i;
      s1_way_q <= access_way_i;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      tree_mem[init_cnt_q] <= '0;
    end else if (rst_n && s1_valid_q) begin
      tree_mem[s1_set_q] <= s1_new;
    end
  end

endmodule

// File: tb/tb_plru_replacer.sv
// tb/tb_plru_replacer.sv - self-checking bench for plru_replacer
// A per-set node-array model is checked every cycle, plus hand-computed victims.
module tb_plru_replacer;

  localparam int W = 4;
  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready_o;
  logic       lookup_valid_i = 1'b0;
  logic [5:0] lookup_set_i = '0;
  logic       victim_valid_o;
  logic [1:0] victim_way_o;
  logic       access_valid_i = 1'b0;
  logic [5:0] access_set_i = '0;
  logic [1:0] access_way_i = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bit m_tree [N][W];
  bit m_ready   = 1'b0;
  int m_cnt     = 0;
  bit exp_valid = 1'b0;
  int exp_way   = 0;

  plru_replacer #(.NUM_OF_WAYS(W), .NUM_OF_SETS(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ready_o        (ready_o),
    .lookup_valid_i (lookup_valid_i),
    .lookup_set_i   (lookup_set_i),
    .victim_valid_o (victim_valid_o),
    .victim_way_o   (victim_way_o),
    .access_valid_i (access_valid_i),
    .access_set_i   (access_set_i),
    .access_way_i   (access_way_i)
  );

  always #5 clk = ~clk;

  function automatic int victim_of(input int s);
    int n;
    n = 1;
    while (n < W) n = 2 * n + int'(m_tree[s][n]);
    return n - W;
  endfunction

  // Architectural model: a lookup sees every earlier access but not the one in its own cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready   <= 1'b0;
      m_cnt     <= 0;
      exp_valid <= 1'b0;
      exp_way   <= 0;
      for (int s = 0; s < N; s++)
        for (int n = 0; n < W; n++) m_tree[s][n] <= 1'b0;
    end else if (!m_ready) begin
      exp_valid <= 1'b0;
      m_cnt     <= m_cnt + 1;
      if (m_cnt + 1 == N) m_ready <= 1'b1;
    end else begin
      exp_valid <= lookup_valid_i;
      if (lookup_valid_i) exp_way <= victim_of(int'(lookup_set_i));
      if (access_valid_i)
        for (int k = 0; k < 2; k++)
          m_tree[access_set_i][(W + int'(access_way_i)) >> (k + 1)] <=
            ((((W + int'(access_way_i)) >> k) % 2) == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", int'(ready_o), int'(m_ready));
      check("victim_valid", int'(victim_valid_o), int'(exp_valid));
      check("victim_way", int'(victim_way_o), exp_way);
    end
  end

  task automatic drive(input bit lv, input int ls, input bit av, input int as, input int aw);
    lookup_valid_i = lv;
    lookup_set_i   = 6'(ls);
    access_valid_i = av;
    access_set_i   = 6'(as);
    access_way_i   = 2'(aw);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic lookup_check(input string name, input int s, input int exp);
    drive(1'b1, s, 1'b0, 0, 0);
    check(name, int'(victim_way_o), exp);
  endtask

  // Called at a negedge right after rst_n is released.
  task automatic sweep_check(input string name);
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      if (i == N - 1) check({name, "_early"}, int'(ready_o), 0);
      if (i == N) check(name, int'(ready_o), 1);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep_check("ready_rise");
    lookup_check("init_set0", 0, 0);
    lookup_check("init_set31", 31, 0);
    lookup_check("init_set63", 63, 0);

    drive(1'b0, 0, 1'b1, 5, 0);
    lookup_check("set5_way0", 5, 2);
    drive(1'b0, 0, 1'b1, 5, 2);
    idle();
    lookup_check("set5_way2", 5, 1);
    drive(1'b0, 0, 1'b1, 5, 1);
    lookup_check("set5_way1", 5, 3);

    drive(1'b1, 9, 1'b1, 9, 0);
    check("read_old", int'(victim_way_o), 0);
    lookup_check("read_old_next", 9, 2);

    drive(1'b0, 0, 1'b1, 3, 0);
    idle();
    lookup_check("isolate_set4", 4, 0);
    lookup_check("isolate_set3", 3, 2);

    drive(1'b0, 0, 1'b1, 7, 0);
    drive(1'b1, 7, 1'b1, 7, 2);
    check("compose_read_old", int'(victim_way_o), 2);
    lookup_check("compose_fwd", 7, 1);

    drive(1'b0, 0, 1'b1, 20, 1);
    drive(1'b0, 0, 1'b1, 21, 3);
    lookup_check("b2b_set20", 20, 2);
    lookup_check("b2b_set21", 21, 0);
    idle();

    for (int i = 0; i < 200; i++)
      drive(i % 3 != 0, (i / 2) % 4, i % 5 != 2, (i * 7 / 3) % 4, (i * 5 + i / 4) % 4);
    idle();
    idle();

    pulse_reset();
    repeat (30) @(negedge clk);
    pulse_reset();
    sweep_check("ready_after_midsweep");
    drive(1'b0, 0, 1'b1, 9, 0);
    lookup_check("fwd_set9", 9, 2);

    drive(1'b0, 0, 1'b1, 2, 0);
    lookup_valid_i = 1'b0;
    access_valid_i = 1'b0;
    pulse_reset();
    sweep_check("ready_after_midaccess");
    for (int s = 0; s < N; s++) lookup_check("swept_set", s, 0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
